// File: rtl/axis_tg_pkt_if.sv
// AXI-Stream link carrying generated packets from the traffic generator towards a NoC ingress.
interface axis_tg_pkt_if #(
  parameter int unsigned TDATA_WIDTH = 512,
  parameter int unsigned TDEST_WIDTH = 2,
  parameter int unsigned TID_WIDTH   = 2
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;

  modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);
endinterface

// File: rtl/axis_tg_pkt.sv
// Multi-flit AXI-Stream packet generator with LFSR-paced offered load, a saturating credit
// bucket and selectable destination patterns; payload carries timestamp, sequence and flit index.
module axis_tg_pkt #(
  parameter int unsigned TID          = 0,
  parameter int unsigned TDATA_WIDTH  = 512,
  parameter int unsigned TDEST_WIDTH  = 2,
  parameter int unsigned TID_WIDTH    = 2,
  parameter int unsigned COUNT_WIDTH  = 32,
  parameter int unsigned MAX_FLITS    = 8,
  parameter int unsigned CREDIT_WIDTH = 4,
  parameter logic [63:0] DEST_SEED    = 64'h48D34421DF9848B,
  parameter logic [15:0] LOAD_SEED    = 16'h92DA,
  localparam int unsigned LEN_WIDTH   = $clog2(MAX_FLITS + 1),
  localparam int unsigned NUM_DEST    = 2 ** TDEST_WIDTH,
  localparam int unsigned HALF_W      = TDATA_WIDTH / 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [15:0]                          load,
  input  logic [COUNT_WIDTH-1:0]               num_packets,
  input  logic [LEN_WIDTH-1:0]                 pkt_len,
  input  logic [1:0]                           mode,
  input  logic [TDEST_WIDTH-1:0]               fixed_dest,
  input  logic                                 start,
  input  logic [HALF_W-1:0]                    ticks,
  output logic                                 done,
  output logic [NUM_DEST-1:0][COUNT_WIDTH-1:0] sent_packets,
  axis_tg_pkt_if.master                        axis_out
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e                               state_q, state_d;
  logic                                 in_pkt_q, in_pkt_d;
  logic [CREDIT_WIDTH-1:0]              credit_q, credit_d;
  logic [COUNT_WIDTH-1:0]               started_q, started_d;
  logic [COUNT_WIDTH-1:0]               completed_q, completed_d;
  logic [NUM_DEST-1:0][COUNT_WIDTH-1:0] sent_q, sent_d;
  logic [LEN_WIDTH-1:0]                 flit_idx_q, flit_idx_d;
  logic [LEN_WIDTH-1:0]                 len_q, len_d;
  logic [TDEST_WIDTH-1:0]               dest_q, dest_d;
  logic [HALF_W-1:0]                    tick_q, tick_d;
  logic [COUNT_WIDTH-1:0]               seq_q, seq_d;
  logic [15:0]                          load_lfsr_q, load_lfsr_d;
  logic [63:0]                          dest_lfsr_q, dest_lfsr_d;

  logic                   running, hs, last_flit, earn, pkt_start;
  logic [LEN_WIDTH-1:0]   len_sel;
  logic [TDEST_WIDTH-1:0] new_dest;

  assign running   = (state_q == StRun);
  assign last_flit = in_pkt_q && (flit_idx_q == len_q - 1'b1);
  assign hs        = in_pkt_q && axis_out.tready;
  assign earn      = running && (load_lfsr_q < load);
  // A new packet may start on the same edge the previous one's last flit is accepted.
  assign pkt_start = running && (!in_pkt_q || (hs && last_flit)) && (credit_q != '0) &&
                     (started_q < num_packets);

  always_comb begin
    len_sel = pkt_len;
    if (pkt_len == '0) begin
      len_sel = LEN_WIDTH'(1);
    end else if (pkt_len > LEN_WIDTH'(MAX_FLITS)) begin
      len_sel = LEN_WIDTH'(MAX_FLITS);
    end
    unique case (mode)
      2'd0:    new_dest = dest_lfsr_q[TDEST_WIDTH-1:0];
      2'd1:    new_dest = ~TDEST_WIDTH'(TID);
      2'd2:    new_dest = TDEST_WIDTH'(TID + 1);
      default: new_dest = fixed_dest;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    in_pkt_d    = in_pkt_q;
    credit_d    = credit_q;
    started_d   = started_q;
    completed_d = completed_q;
    sent_d      = sent_q;
    flit_idx_d  = flit_idx_q;
    len_d       = len_q;
    dest_d      = dest_q;
    tick_d      = tick_q;
    seq_d       = seq_q;
    dest_lfsr_d = dest_lfsr_q;
    load_lfsr_d = {load_lfsr_q[14:0],
                   ~(load_lfsr_q[15] ^ load_lfsr_q[14] ^ load_lfsr_q[12] ^ load_lfsr_q[3])};

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StRun;
          credit_d    = '0;
          started_d   = '0;
          completed_d = '0;
          sent_d      = '0;
        end
      end
      default: begin
        if ((completed_q == num_packets) && !in_pkt_q) state_d = StIdle;
      end
    endcase

    if (earn && !pkt_start) begin
      if (credit_q != '1) credit_d = credit_q + 1'b1;
    end else if (!earn && pkt_start) begin
      credit_d = credit_q - 1'b1;
    end

    if (hs) begin
      if (last_flit) begin
        in_pkt_d        = 1'b0;
        flit_idx_d      = '0;
        completed_d     = completed_q + 1'b1;
        sent_d[dest_q]  = sent_q[dest_q] + 1'b1;
      end else begin
        flit_idx_d = flit_idx_q + 1'b1;
      end
    end

    if (pkt_start) begin
      in_pkt_d   = 1'b1;
      flit_idx_d = '0;
      started_d  = started_q + 1'b1;
      len_d      = len_sel;
      dest_d     = new_dest;
      tick_d     = ticks;
      // Post-update count so a back-to-back packet to the same destination gets the next seq.
      seq_d      = sent_d[new_dest];
      if (mode == 2'd0) begin
        dest_lfsr_d = {dest_lfsr_q[62:0],
                       ~(dest_lfsr_q[63] ^ dest_lfsr_q[62] ^ dest_lfsr_q[60] ^ dest_lfsr_q[59])};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      in_pkt_q    <= 1'b0;
      credit_q    <= '0;
      started_q   <= '0;
      completed_q <= '0;
      sent_q      <= '0;
      flit_idx_q  <= '0;
      len_q       <= '0;
      dest_q      <= '0;
      tick_q      <= '0;
      seq_q       <= '0;
      load_lfsr_q <= LOAD_SEED;
      dest_lfsr_q <= DEST_SEED;
    end else begin
      state_q     <= state_d;
      in_pkt_q    <= in_pkt_d;
      credit_q    <= credit_d;
      started_q   <= started_d;
      completed_q <= completed_d;
      sent_q      <= sent_d;
      flit_idx_q  <= flit_idx_d;
      len_q       <= len_d;
      dest_q      <= dest_d;
      tick_q      <= tick_d;
      seq_q       <= seq_d;
      load_lfsr_q <= load_lfsr_d;
      dest_lfsr_q <= dest_lfsr_d;
    end
  end

  always_comb begin
    axis_out.tdata                          = '0;
    axis_out.tdata[COUNT_WIDTH-1:0]         = seq_q;
    axis_out.tdata[COUNT_WIDTH +: 8]        = 8'(flit_idx_q);
    axis_out.tdata[TDATA_WIDTH-1 -: HALF_W] = tick_q;
  end

  assign axis_out.tvalid = in_pkt_q;
  assign axis_out.tlast  = last_flit;
  assign axis_out.tdest  = dest_q;
  assign axis_out.tid    = TID_WIDTH'(TID);
  assign done            = (state_q == StIdle);
  assign sent_packets    = sent_q;

endmodule
